// File: rtl/alu_pkg.sv
// Shared op codes and FSM state encoding for the multi-cycle ALU.
package alu_pkg;

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_NOT = 4'b0010;
  localparam logic [3:0] OP_AND = 4'b0011;
  localparam logic [3:0] OP_OR  = 4'b0100;
  localparam logic [3:0] OP_XOR = 4'b0101;
  localparam logic [3:0] OP_SLT = 4'b0110;
  localparam logic [3:0] OP_EQ  = 4'b0111;
  localparam logic [3:0] OP_SLL = 4'b1000;
  localparam logic [3:0] OP_SRL = 4'b1001;
  localparam logic [3:0] OP_SRA = 4'b1010;
  localparam logic [3:0] OP_MUL = 4'b1011;

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } state_t;

endpackage

// File: rtl/alu_comb.sv
// Combinational core for single-cycle ops (0000-0111); shifts, MUL and reserved codes give 0.
// No latency or backpressure of its own: the caller registers the outputs.
module alu_comb import alu_pkg::*; #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       op,
  output logic [WIDTH-1:0] result,
  output logic             c_out,
  output logic             of
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] dif;

  always_comb begin
    sum    = {1'b0, a} + {1'b0, b};
    dif    = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
    result = '0;
    c_out  = 1'b0;
    of     = 1'b0;
    case (op)
      OP_ADD: begin
        result = sum[WIDTH-1:0];
        c_out  = sum[WIDTH];
        of     = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        // c_out high means no borrow
        result = dif[WIDTH-1:0];
        c_out  = dif[WIDTH];
        of     = (a[WIDTH-1] != b[WIDTH-1]) && (dif[WIDTH-1] != a[WIDTH-1]);
      end
      OP_NOT: result = ~a;
      OP_AND: result = a & b;
      OP_OR:  result = a | b;
      OP_XOR: result = a ^ b;
      OP_SLT: result = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_EQ:  result = {{(WIDTH-1){1'b0}}, (a == b)};
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_seq.sv
// Multi-cycle ALU: single-cycle ops 1 cycle, shifts 1+k, MUL 1+WIDTH to out_valid.
// Result holds while out_valid && !out_ready; in_ready is low from accept until the result is taken.
module alu_seq import alu_pkg::*; #(
  parameter  int WIDTH = 8,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             c_out,
  output logic             of
);

  localparam logic [SHW:0] CNT_MUL = (SHW+1)'(WIDTH);
  localparam logic [SHW:0] CNT_ONE = (SHW+1)'(1);

  state_t               state, state_nxt;
  logic [3:0]           op_r;
  logic [WIDTH-1:0]     mcand;
  logic [2*WIDTH-1:0]   acc, acc_nxt;
  logic [SHW:0]         cnt;
  logic [WIDTH:0]       add_sum;
  logic [WIDTH-1:0]     core_res, imm_res;
  logic                 core_c, core_of;
  logic                 is_shift, is_mul, go_busy;
  logic [SHW-1:0]       k;

  alu_comb #(.WIDTH(WIDTH)) u_core (
    .a      (a),
    .b      (b),
    .op     (op),
    .result (core_res),
    .c_out  (core_c),
    .of     (core_of)
  );

  assign k        = b[SHW-1:0];
  assign is_shift = (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
  assign is_mul   = (op == OP_MUL);
  assign go_busy  = is_mul || (is_shift && (k != '0));
  assign imm_res  = is_shift ? a : core_res;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = go_busy ? S_BUSY : S_DONE;
      end
      S_BUSY: if (cnt == CNT_ONE) state_nxt = S_DONE;
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // acc is {high, low}: shifts work in the low half with the high half kept zero;
  // MUL starts with b in the low half and shifts the partial product in from the top.
  always_comb begin
    acc_nxt = acc;
    add_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mcand} : '0);
    case (op_r)
      OP_SLL:  acc_nxt = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-2:0], 1'b0};
      OP_SRL:  acc_nxt = {acc[2*WIDTH-1:WIDTH], 1'b0, acc[WIDTH-1:1]};
      OP_SRA:  acc_nxt = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1], acc[WIDTH-1:1]};
      default: acc_nxt = {add_sum, acc[WIDTH-1:1]};
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_r   <= OP_ADD;
      mcand  <= '0;
      acc    <= '0;
      cnt    <= '0;
      result <= '0;
      zero   <= 1'b0;
      c_out  <= 1'b0;
      of     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (in_valid) begin
          op_r  <= op;
          mcand <= a;
          acc   <= {{WIDTH{1'b0}}, (is_mul ? b : a)};
          cnt   <= is_mul ? CNT_MUL : {1'b0, k};
          if (!go_busy) begin
            result <= imm_res;
            zero   <= (imm_res == '0);
            c_out  <= core_c;
            of     <= core_of;
          end
        end
        S_BUSY: begin
          acc <= acc_nxt;
          cnt <= cnt - 1'b1;
          if (cnt == CNT_ONE) begin
            result <= acc_nxt[WIDTH-1:0];
            zero   <= (acc_nxt[WIDTH-1:0] == '0);
            c_out  <= 1'b0;
            of     <= (op_r == OP_MUL) && (|acc_nxt[2*WIDTH-1:WIDTH]);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq at WIDTH=8: vector table plus backpressure and reset-abort sequences.
module tb_alu_seq;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic [3:0]   op = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] result;
  logic         zero, c_out, of;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  alu_seq #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .op        (op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero),
    .c_out     (c_out),
    .of        (of)
  );

  typedef struct {
    logic [7:0] va;
    logic [7:0] vb;
    logic [3:0] vop;
    logic [7:0] res;
    logic       z;
    logic       c;
    logic       o;
    int         lat;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic [7:0] va, input logic [7:0] vb, input logic [3:0] vop,
                              input logic [7:0] res, input logic z, input logic c, input logic o,
                              input int lat);
    vec_t v;
    v.va = va; v.vb = vb; v.vop = vop; v.res = res; v.z = z; v.c = c; v.o = o; v.lat = lat;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Present one op, wait for the accept edge, then count cycles until out_valid (1 = next cycle).
  task automatic run_op(input logic [7:0] ta, input logic [7:0] tb, input logic [3:0] top,
                        output int lat);
    int guard;
    guard = 0;
    @(negedge clk);
    while (!in_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    a = ta; b = tb; op = top; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic collect(input string name);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check(name, {30'd0, out_valid, in_ready}, 32'b01);
  endtask

  initial begin
    int lat;
    logic seen;

    vecs.push_back(mk(8'h7F, 8'h01, 4'h0, 8'h80, 0, 0, 1, 1));  // ADD signed overflow
    vecs.push_back(mk(8'hFF, 8'h01, 4'h0, 8'h00, 1, 1, 0, 1));  // ADD carry out
    vecs.push_back(mk(8'h05, 8'h05, 4'h1, 8'h00, 1, 1, 0, 1));  // SUB equal
    vecs.push_back(mk(8'h00, 8'h01, 4'h1, 8'hFF, 0, 0, 0, 1));  // SUB borrow
    vecs.push_back(mk(8'h80, 8'h01, 4'h1, 8'h7F, 0, 1, 1, 1));  // SUB overflow
    vecs.push_back(mk(8'h0F, 8'h00, 4'h2, 8'hF0, 0, 0, 0, 1));
    vecs.push_back(mk(8'hF0, 8'h3C, 4'h3, 8'h30, 0, 0, 0, 1));
    vecs.push_back(mk(8'hF0, 8'h0F, 4'h4, 8'hFF, 0, 0, 0, 1));
    vecs.push_back(mk(8'hAA, 8'hAA, 4'h5, 8'h00, 1, 0, 0, 1));
    vecs.push_back(mk(8'hFF, 8'h01, 4'h6, 8'h01, 0, 0, 0, 1));  // -1 < 1
    vecs.push_back(mk(8'h01, 8'hFF, 4'h6, 8'h00, 1, 0, 0, 1));
    vecs.push_back(mk(8'h80, 8'h7F, 4'h6, 8'h01, 0, 0, 0, 1));
    vecs.push_back(mk(8'h5A, 8'h5A, 4'h7, 8'h01, 0, 0, 0, 1));
    vecs.push_back(mk(8'h5A, 8'h5B, 4'h7, 8'h00, 1, 0, 0, 1));
    vecs.push_back(mk(8'h81, 8'h00, 4'h8, 8'h81, 0, 0, 0, 1));  // zero-amount shift
    vecs.push_back(mk(8'h81, 8'h01, 4'h8, 8'h02, 0, 0, 0, 2));
    vecs.push_back(mk(8'h81, 8'h07, 4'h9, 8'h01, 0, 0, 0, 8));
    vecs.push_back(mk(8'hF0, 8'h0B, 4'h9, 8'h1E, 0, 0, 0, 4));  // upper b bits ignored
    vecs.push_back(mk(8'h80, 8'h03, 4'hA, 8'hF0, 0, 0, 0, 4));
    vecs.push_back(mk(8'h40, 8'h03, 4'hA, 8'h08, 0, 0, 0, 4));
    vecs.push_back(mk(8'h10, 8'h11, 4'hB, 8'h10, 0, 0, 1, 9));
    vecs.push_back(mk(8'h0F, 8'h0F, 4'hB, 8'hE1, 0, 0, 0, 9));
    vecs.push_back(mk(8'hFF, 8'hFF, 4'hB, 8'h01, 0, 0, 1, 9));
    vecs.push_back(mk(8'h00, 8'h37, 4'hB, 8'h00, 1, 0, 0, 9));
    vecs.push_back(mk(8'h10, 8'h10, 4'hB, 8'h00, 1, 0, 1, 9));
    vecs.push_back(mk(8'hFF, 8'hFF, 4'hC, 8'h00, 1, 0, 0, 1));  // reserved
    vecs.push_back(mk(8'h12, 8'h34, 4'hF, 8'h00, 1, 0, 0, 1));

    #2 rst_n = 1'b0;
    #10;
    check("reset_outputs", {20'd0, result, zero, c_out, of, out_valid, in_ready},
          {20'd0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1});
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_reset_ready", {30'd0, out_valid, in_ready}, 32'b01);

    for (int i = 0; i < vecs.size(); i++) begin
      run_op(vecs[i].va, vecs[i].vb, vecs[i].vop, lat);
      check($sformatf("vec%0d_out", i), {21'd0, result, zero, c_out, of},
            {21'd0, vecs[i].res, vecs[i].z, vecs[i].c, vecs[i].o});
      check($sformatf("vec%0d_lat", i), lat, vecs[i].lat);
      collect($sformatf("vec%0d_release", i));
    end

    // Backpressure: consumer stalls while upstream keeps offering new operands.
    run_op(8'h7F, 8'h01, 4'h0, lat);
    check("bp_lat", lat, 1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid = ~in_valid;
      a = a + 8'h11;
      @(posedge clk); #1;
      check($sformatf("bp_hold%0d", i), {19'd0, out_valid, in_ready, result, zero, c_out, of},
            {19'd0, 1'b1, 1'b0, 8'h80, 1'b0, 1'b0, 1'b1});
    end
    @(negedge clk);
    in_valid = 1'b0;
    collect("bp_release");
    @(posedge clk); #1;
    check("bp_no_new_op", {30'd0, out_valid, in_ready}, 32'b01);

    // Reset in the middle of a MUL aborts it.
    @(negedge clk);
    a = 8'h10; b = 8'h11; op = 4'hB; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_outputs", {20'd0, result, zero, c_out, of, out_valid, in_ready},
          {20'd0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1});
    @(negedge clk);
    rst_n = 1'b1;
    a = 8'h7F; b = 8'h01; op = 4'h0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("abort_add_out", {19'd0, out_valid, in_ready, result, zero, c_out, of},
          {19'd0, 1'b1, 1'b0, 8'h80, 1'b0, 1'b0, 1'b1});
    collect("abort_add_release");
    seen = 1'b0;
    repeat (12) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    check("abort_no_stale", {31'd0, seen}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
